inst_fetch: RTL and testbench

Instruction-fetch stage of the five-stage core, directly upstream of the IF/ID pipeline register. It owns the PC, issues one instruction-cache access per cycle, tracks cache misses and branch/jump redirects, and holds a captured instruction while the downstream stage is frozen. Its outputs feed IF/ID's instruction, PC and bubble inputs; a bubble is encoded as all-zero instruction and PC.

---
 rtl/inst_fetch_pkg.sv | 21 ++
 rtl/fetch_hold_buf.sv | 35 +++
 rtl/inst_fetch.sv | 143 ++++++++++++++
 tb/tb_inst_fetch.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package inst_fetch_pkg;

    localparam int DATA_WID = 32;

    // A bubble is presented to IF/ID as an all-zero instruction and PC.
    localparam logic [DATA_WID-1:0] NOP_BUBBLE = 32'h0000_0000;

    // Fetch control states.
    //   RUN         : normal fetch, one access per cycle
    //   MISS        : refill outstanding, result still wanted
    //   MISS_SQUASH : refill outstanding, result is wrong-path (target in tgt_buf)
    //   HELD        : captured instruction waits for hold to drop
    typedef enum logic [1:0] {
        RUN         = 2'd0,
        MISS        = 2'd1,
        MISS_SQUASH = 2'd2,
        HELD        = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// Capture register for an instruction/PC pair while downstream is frozen.
module fetch_hold_buf
    import inst_fetch_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic                i_clear,
    input  logic [DATA_WID-1:0] i_inst,
    input  logic [DATA_WID-1:0] i_pc,
    output logic [DATA_WID-1:0] o_inst,
    output logic [DATA_WID-1:0] o_pc
);

    logic [DATA_WID-1:0] r_inst;
    logic [DATA_WID-1:0] r_pc;

    // Clear wins over load so a dropped buffer never retains stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst <= NOP_BUBBLE;
            r_pc   <= NOP_BUBBLE;
        end else if (i_clear) begin
            r_inst <= NOP_BUBBLE;
            r_pc   <= NOP_BUBBLE;
        end else if (i_load) begin
            r_inst <= i_inst;
            r_pc   <= i_pc;
        end
    end

    assign o_inst = r_inst;
    assign o_pc   = r_pc;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, drives the I-cache, handles misses,
// redirects and downstream holds, and feeds IF/ID.
//
// Handshake: the I-cache result is valid exactly in cycles where
// icache_req=1 and icache_stall=0; IF/ID accepts inst_out/pc_out at the next
// edge whenever bubble=0 (hold=1 means it will not accept this cycle).
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [DATA_WID-1:0] RESET_PC = 32'h0000_0000
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                hold,
    input  logic                redirect,
    input  logic [DATA_WID-1:0] redirect_pc,
    output logic                icache_req,
    output logic [DATA_WID-1:0] icache_addr,
    input  logic [DATA_WID-1:0] icache_inst,
    input  logic                icache_stall,
    output logic [DATA_WID-1:0] inst_out,
    output logic [DATA_WID-1:0] pc_out,
    output logic                bubble,
    output fetch_state_t        dbg_state
);

    fetch_state_t        r_state;
    fetch_state_t        w_state_nxt;
    logic [DATA_WID-1:0] r_pc;
    logic [DATA_WID-1:0] w_pc_nxt;
    logic [DATA_WID-1:0] r_tgt_buf;
    logic [DATA_WID-1:0] w_tgt_nxt;
    logic                w_hb_load;
    logic                w_hb_clear;
    logic [DATA_WID-1:0] w_hb_inst;
    logic [DATA_WID-1:0] w_hb_pc;
    logic                w_req;
    logic                w_bubble;
    logic [DATA_WID-1:0] w_inst;
    logic [DATA_WID-1:0] w_pc_o;

    fetch_hold_buf u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_hb_load),
        .i_clear (w_hb_clear),
        .i_inst  (icache_inst),
        .i_pc    (r_pc),
        .o_inst  (w_hb_inst),
        .o_pc    (w_hb_pc)
    );

    // State, PC and saved redirect target registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= RUN;
            r_pc      <= RESET_PC;
            r_tgt_buf <= NOP_BUBBLE;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_tgt_buf <= w_tgt_nxt;
        end
    end

    // Next-state, PC update and output selection.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_tgt_nxt   = r_tgt_buf;
        w_hb_load   = 1'b0;
        w_hb_clear  = 1'b0;
        w_req       = 1'b1;
        w_bubble    = 1'b1;
        w_inst      = NOP_BUBBLE;
        w_pc_o      = NOP_BUBBLE;
        case (r_state)
            RUN, MISS: begin
                if (r_state == MISS && icache_stall) begin
                    // Refill still running: PC frozen, remember any redirect.
                    if (redirect) begin
                        w_tgt_nxt   = redirect_pc;
                        w_state_nxt = MISS_SQUASH;
                    end
                end else if (redirect) begin
                    w_pc_nxt    = redirect_pc;
                    w_state_nxt = RUN;
                end else if (icache_stall) begin
                    w_state_nxt = MISS;
                end else if (hold) begin
                    w_hb_load   = 1'b1;
                    w_state_nxt = HELD;
                end else begin
                    w_bubble    = 1'b0;
                    w_inst      = icache_inst;
                    w_pc_o      = r_pc;
                    w_pc_nxt    = r_pc + 32'd4;
                    w_state_nxt = RUN;
                end
            end
            MISS_SQUASH: begin
                // Wrong-path refill: the returned word is never emitted.
                if (icache_stall) begin
                    if (redirect) begin
                        w_tgt_nxt = redirect_pc;
                    end
                end else begin
                    w_pc_nxt    = redirect ? redirect_pc : r_tgt_buf;
                    w_state_nxt = RUN;
                end
            end
            HELD: begin
                w_req = 1'b0;
                if (redirect) begin
                    w_hb_clear  = 1'b1;
                    w_pc_nxt    = redirect_pc;
                    w_state_nxt = RUN;
                end else begin
                    w_bubble = 1'b0;
                    w_inst   = w_hb_inst;
                    w_pc_o   = w_hb_pc;
                    if (!hold) begin
                        w_hb_clear  = 1'b1;
                        w_pc_nxt    = r_pc + 32'd4;
                        w_state_nxt = RUN;
                    end
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // Reset forces a bubble immediately, independent of the clock.
    assign icache_req  = w_req & ~rst;
    assign bubble      = w_bubble | rst;
    assign inst_out    = rst ? NOP_BUBBLE : w_inst;
    assign pc_out      = rst ? NOP_BUBBLE : w_pc_o;
    assign icache_addr = r_pc;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus random traffic
// against a behavioural fetch model.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic         clk;
    logic         rst;
    logic         hold;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic         icache_req;
    logic [31:0]  icache_addr;
    logic [31:0]  icache_inst;
    logic         icache_stall;
    logic [31:0]  inst_out;
    logic [31:0]  pc_out;
    logic         bubble;
    fetch_state_t dbg_state;

    int checks;
    int failures;
    int cyc;

    // Behavioural model: PC, outstanding refill, wrong-path flag, held entry.
    logic [31:0] m_pc;
    bit          m_busy;
    bit          m_wrong;
    logic [31:0] m_tgt;
    bit          m_held;
    logic [31:0] m_hinst;
    logic [31:0] m_hpc;

    inst_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .hold         (hold),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .icache_req   (icache_req),
        .icache_addr  (icache_addr),
        .icache_inst  (icache_inst),
        .icache_stall (icache_stall),
        .inst_out     (inst_out),
        .pc_out       (pc_out),
        .bubble       (bubble),
        .dbg_state    (dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents as a function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // Cache: returns garbage while stalling, memory contents on a hit.
    assign icache_inst = icache_stall ? 32'hDEAD_BEEF : mem_word(icache_addr);

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_busy  = 1'b0;
        m_wrong = 1'b0;
        m_tgt   = 32'h0;
        m_held  = 1'b0;
        m_hinst = 32'h0;
        m_hpc   = 32'h0;
    endtask

    // One clock cycle: drive inputs, compare against model, advance both.
    task automatic drive_cycle(input bit s, input bit h, input bit r, input logic [31:0] rp);
        logic        e_req;
        logic        e_bub;
        logic [31:0] e_inst;
        logic [31:0] e_pco;
        @(negedge clk);
        icache_stall = s;
        hold         = h;
        redirect     = r;
        redirect_pc  = rp;
        #1;
        e_req  = !m_held;
        e_bub  = 1'b1;
        e_inst = 32'h0;
        e_pco  = 32'h0;
        if (icache_addr !== m_pc) begin
            $display("FAIL addr cyc=%0d: got %h exp %h", cyc, icache_addr, m_pc);
            failures++;
        end
        checks++;
        if (m_held) begin
            if (r) begin
                m_held = 1'b0;
                m_pc   = rp;
            end else begin
                e_bub  = 1'b0;
                e_inst = m_hinst;
                e_pco  = m_hpc;
                if (!h) begin
                    m_held = 1'b0;
                    m_pc   = m_pc + 32'd4;
                end
            end
        end else if (m_busy && m_wrong) begin
            if (!s) begin
                m_pc    = r ? rp : m_tgt;
                m_busy  = 1'b0;
                m_wrong = 1'b0;
            end else if (r) begin
                m_tgt = rp;
            end
        end else if (m_busy && s) begin
            if (r) begin
                m_wrong = 1'b1;
                m_tgt   = rp;
            end
        end else begin
            m_busy = 1'b0;
            if (r) begin
                m_pc = rp;
            end else if (s) begin
                m_busy = 1'b1;
            end else if (h) begin
                m_held  = 1'b1;
                m_hinst = mem_word(m_pc);
                m_hpc   = m_pc;
            end else begin
                e_bub  = 1'b0;
                e_inst = mem_word(m_pc);
                e_pco  = m_pc;
                m_pc   = m_pc + 32'd4;
            end
        end
        if (icache_req !== e_req) begin
            $display("FAIL req cyc=%0d: got %b exp %b", cyc, icache_req, e_req);
            failures++;
        end
        checks++;
        if (bubble !== e_bub) begin
            $display("FAIL bubble cyc=%0d: got %b exp %b", cyc, bubble, e_bub);
            failures++;
        end
        checks++;
        if (inst_out !== e_inst) begin
            $display("FAIL inst_out cyc=%0d: got %h exp %h", cyc, inst_out, e_inst);
            failures++;
        end
        checks++;
        if (pc_out !== e_pco) begin
            $display("FAIL pc_out cyc=%0d: got %h exp %h", cyc, pc_out, e_pco);
            failures++;
        end
        checks++;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        if (icache_req !== 1'b0 || bubble !== 1'b1 || inst_out !== 32'h0 || pc_out !== 32'h0) begin
            $display("FAIL reset_out: got req=%b bub=%b inst=%h pc=%h exp 0/1/0/0",
                     icache_req, bubble, inst_out, pc_out);
            failures++;
        end
        checks++;
        @(posedge clk);
        #1;
        if (icache_addr !== RESET_PC || dbg_state !== RUN) begin
            $display("FAIL reset_state: got addr=%h st=%0d exp %h/0", icache_addr, dbg_state, RESET_PC);
            failures++;
        end
        checks++;
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_sequential();
        test_reset();
        for (int i = 0; i < 4; i++) drive_cycle(0, 0, 0, 32'h0);
        if (icache_addr !== 32'h10) begin
            $display("FAIL seq_addr: got %h exp 00000010", icache_addr);
            failures++;
        end
        checks++;
    endtask

    task automatic test_miss();
        test_reset();
        drive_cycle(0, 0, 0, 32'h0);
        drive_cycle(0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) drive_cycle(1, 0, 0, 32'h0);
        drive_cycle(0, 0, 0, 32'h0);
        if (icache_addr !== 32'hC) begin
            $display("FAIL miss_next: got %h exp 0000000c", icache_addr);
            failures++;
        end
        checks++;
    endtask

    task automatic test_redirect_in_miss();
        test_reset();
        drive_cycle(0, 0, 0, 32'h0);
        drive_cycle(0, 0, 0, 32'h0);
        drive_cycle(1, 0, 0, 32'h0);
        drive_cycle(1, 0, 1, 32'h100);
        drive_cycle(1, 0, 1, 32'h200);
        drive_cycle(1, 0, 0, 32'h0);
        drive_cycle(0, 0, 0, 32'h0);
        if (icache_addr !== 32'h200) begin
            $display("FAIL squash_tgt: got %h exp 00000200", icache_addr);
            failures++;
        end
        checks++;
        drive_cycle(0, 0, 0, 32'h0);
    endtask

    task automatic test_hold();
        test_reset();
        drive_cycle(0, 0, 0, 32'h0);
        drive_cycle(0, 1, 0, 32'h0);
        drive_cycle(0, 1, 0, 32'h0);
        drive_cycle(0, 0, 0, 32'h0);
        if (icache_addr !== 32'h8) begin
            $display("FAIL hold_next: got %h exp 00000008", icache_addr);
            failures++;
        end
        checks++;
        drive_cycle(0, 0, 0, 32'h0);
    endtask

    task automatic test_held_redirect();
        test_reset();
        drive_cycle(0, 0, 0, 32'h0);
        drive_cycle(0, 1, 0, 32'h0);
        drive_cycle(0, 1, 1, 32'h40);
        if (icache_addr !== 32'h40) begin
            $display("FAIL held_redir: got %h exp 00000040", icache_addr);
            failures++;
        end
        checks++;
        drive_cycle(0, 0, 0, 32'h0);
    endtask

    task automatic test_wrap();
        test_reset();
        drive_cycle(0, 0, 1, 32'hFFFF_FFFC);
        drive_cycle(0, 0, 0, 32'h0);
        if (icache_addr !== 32'h0) begin
            $display("FAIL wrap: got %h exp 00000000", icache_addr);
            failures++;
        end
        checks++;
    endtask

    task automatic test_async_reset_mid_miss();
        test_reset();
        drive_cycle(0, 0, 1, 32'h80);
        drive_cycle(1, 0, 0, 32'h0);
        drive_cycle(1, 0, 0, 32'h0);
        #3;
        rst = 1'b1;
        #1;
        if (icache_req !== 1'b0 || bubble !== 1'b1 || inst_out !== 32'h0 ||
            pc_out !== 32'h0 || icache_addr !== RESET_PC) begin
            $display("FAIL async_rst: got req=%b bub=%b inst=%h pc=%h addr=%h exp 0/1/0/0/%h",
                     icache_req, bubble, inst_out, pc_out, icache_addr, RESET_PC);
            failures++;
        end
        checks++;
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        drive_cycle(0, 0, 0, 32'h0);
        drive_cycle(0, 0, 0, 32'h0);
    endtask

    task automatic test_random();
        test_reset();
        for (int i = 0; i < 600; i++) begin
            drive_cycle($urandom_range(0, 3) == 0,
                        $urandom_range(0, 4) == 0,
                        $urandom_range(0, 6) == 0,
                        {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        cyc          = 0;
        rst          = 1'b0;
        hold         = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = 32'h0;
        icache_stall = 1'b0;
        model_reset();
        test_sequential();
        test_miss();
        test_redirect_in_miss();
        test_hold();
        test_held_redirect();
        test_wrap();
        test_async_reset_mid_miss();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
